// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, instruction
// classes, RV32I opcode/funct constants and small class-query helpers.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   // ILL is encoded as zero so a cleared class register reads as "nothing legal".
   typedef enum logic [2:0] {
      CLS_ILL  = 3'd0,
      CLS_LD   = 3'd1,
      CLS_ST   = 3'd2,
      CLS_ADD  = 3'd3,
      CLS_SUB  = 3'd4,
      CLS_ADDI = 3'd5,
      CLS_BEQ  = 3'd6
   } instr_class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   localparam int WAIT_W = 4;

   function automatic logic class_uses_imm(input instr_class_e cls);
      return (cls == CLS_LD) || (cls == CLS_ST) || (cls == CLS_ADDI);
   endfunction

   function automatic logic class_subtracts(input instr_class_e cls);
      return (cls == CLS_SUB) || (cls == CLS_BEQ);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_class_decoder.sv
// Combinational instruction classifier: maps the raw IR word onto one of the
// instruction classes. beq is only recognised when CTRL_BRANCH_EN is defined.
module instr_class_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [2:0]  instr_class
);

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic [6:0]   funct7;
   instr_class_e cls;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];

   always_comb begin
      cls = CLS_ILL;
      case (opcode)
         OPC_LOAD: begin
            if (funct3 == F3_WORD) cls = CLS_LD;
         end
         OPC_STORE: begin
            if (funct3 == F3_WORD) cls = CLS_ST;
         end
         OPC_OP: begin
            if (funct3 == F3_ADD) begin
               if (funct7 == F7_ADD)      cls = CLS_ADD;
               else if (funct7 == F7_SUB) cls = CLS_SUB;
            end
         end
         OPC_OP_IMM: begin
            if (funct3 == F3_ADD) cls = CLS_ADDI;
         end
`ifdef CTRL_BRANCH_EN
         OPC_BRANCH: begin
            if (funct3 == F3_BEQ) cls = CLS_BEQ;
         end
`endif
         default: cls = CLS_ILL;
      endcase
   end

   assign instr_class = cls;

   // Register and immediate fields carry no control information.
   logic unused_fields;
   assign unused_fields = ^{instruction[24:15], instruction[11:7]};

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the load-store datapath (lw, sw, add, sub, addi).
// Optional beq support is enabled by defining CTRL_BRANCH_EN.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_WAIT = 0
)(
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        ULA_zero,
   output logic        load_ir,
   output logic        load_pc,
   output logic        pc_src,
   output logic        sub,
   output logic        ULA_din2_sel,
   output logic        RF_din_sel,
   output logic        WE_RF,
   output logic        WE_MEM,
   output logic        illegal
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

   state_e            state_q, state_d;
   instr_class_e      cls_q, cls_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [2:0]        dec_cls;
   logic              wait_done;

   instr_class_decoder u_decoder (
      .instruction (instruction),
      .instr_class (dec_cls)
   );

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         cls_q   <= CLS_ILL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wait_done = (cnt_q == WAIT_LAST);

   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      cnt_d        = '0;
      load_ir      = 1'b0;
      load_pc      = 1'b0;
      pc_src       = 1'b0;
      sub          = 1'b0;
      ULA_din2_sel = 1'b0;
      RF_din_sel   = 1'b0;
      WE_RF        = 1'b0;
      WE_MEM       = 1'b0;
      illegal      = 1'b0;

      case (state_q)
         ST_INIT: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            if (wait_done) begin
               load_ir = 1'b1;
               state_d = ST_DECODE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // The class is captured here; the IR may change freely afterwards.
         ST_DECODE: begin
            cls_d   = instr_class_e'(dec_cls);
            state_d = (cls_d == CLS_ILL) ? ST_HALT : ST_EXEC;
         end

         ST_EXEC: begin
            ULA_din2_sel = class_uses_imm(cls_q);
            sub          = class_subtracts(cls_q);
            case (cls_q)
               CLS_LD, CLS_ST:            state_d = ST_MEM;
               CLS_ADD, CLS_SUB, CLS_ADDI: state_d = ST_WB;
`ifdef CTRL_BRANCH_EN
               CLS_BEQ: begin
                  ULA_din2_sel = 1'b0;
                  load_pc      = 1'b1;
                  pc_src       = ULA_zero;
                  state_d      = ST_FETCH;
               end
`endif
               default:                   state_d = ST_HALT;
            endcase
         end

         ST_MEM: begin
            ULA_din2_sel = 1'b1;
            if (wait_done) begin
               if (cls_q == CLS_ST) begin
                  WE_MEM  = 1'b1;
                  load_pc = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // ALU selects stay as in EXEC so the result stays valid during the write.
         ST_WB: begin
            WE_RF        = 1'b1;
            load_pc      = 1'b1;
            RF_din_sel   = (cls_q != CLS_LD);
            ULA_din2_sel = class_uses_imm(cls_q);
            sub          = class_subtracts(cls_q);
            state_d      = ST_FETCH;
         end

         ST_HALT: begin
            illegal = 1'b1;
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

`ifndef CTRL_BRANCH_EN
   logic unused_zero;
   assign unused_zero = ULA_zero;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected control timelines are built
// from the instruction semantics and compared cycle by cycle.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic load_ir;
      logic load_pc;
      logic pc_src;
      logic sub;
      logic din2;
      logic rfsel;
      logic we_rf;
      logic we_mem;
      logic illegal;
   } ctl_t;

   localparam int K_ILL  = 0;
   localparam int K_LW   = 1;
   localparam int K_SW   = 2;
   localparam int K_ADD  = 3;
   localparam int K_SUB  = 4;
   localparam int K_ADDI = 5;
   localparam int K_BEQ  = 6;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr0 = '0, instr2 = '0;
   logic        zero0 = 1'b0, zero2 = 1'b0;
   ctl_t        obs0, obs2;

   int checks = 0;
   int errors = 0;

   logic a_load_ir, a_load_pc, a_pc_src, a_sub, a_din2, a_rfsel, a_we_rf, a_we_mem, a_ill;
   logic b_load_ir, b_load_pc, b_pc_src, b_sub, b_din2, b_rfsel, b_we_rf, b_we_mem, b_ill;

   always #5 CLK = ~CLK;

   multicycle_control_unit #(.MEM_WAIT(0)) dut0 (
      .CLK(CLK), .reset(reset), .instruction(instr0), .ULA_zero(zero0),
      .load_ir(a_load_ir), .load_pc(a_load_pc), .pc_src(a_pc_src), .sub(a_sub),
      .ULA_din2_sel(a_din2), .RF_din_sel(a_rfsel), .WE_RF(a_we_rf), .WE_MEM(a_we_mem),
      .illegal(a_ill)
   );

   multicycle_control_unit #(.MEM_WAIT(2)) dut2 (
      .CLK(CLK), .reset(reset), .instruction(instr2), .ULA_zero(zero2),
      .load_ir(b_load_ir), .load_pc(b_load_pc), .pc_src(b_pc_src), .sub(b_sub),
      .ULA_din2_sel(b_din2), .RF_din_sel(b_rfsel), .WE_RF(b_we_rf), .WE_MEM(b_we_mem),
      .illegal(b_ill)
   );

   assign obs0 = {a_load_ir, a_load_pc, a_pc_src, a_sub, a_din2, a_rfsel, a_we_rf, a_we_mem, a_ill};
   assign obs2 = {b_load_ir, b_load_pc, b_pc_src, b_sub, b_din2, b_rfsel, b_we_rf, b_we_mem, b_ill};

   function automatic int classify(input logic [31:0] ins);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
      if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
      if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
      if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
      if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
`ifdef CTRL_BRANCH_EN
      if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
`endif
      return K_ILL;
   endfunction

   // Expected outputs for every cycle of one instruction, FETCH onwards.
   task automatic build_trace(input logic [31:0] ins, input int mw, input logic z,
                              output ctl_t tr[$]);
      int   k;
      ctl_t c;
      logic imm, sb;
      tr = {};
      k  = classify(ins);
      for (int i = 0; i < mw; i++) tr.push_back(ctl_t'(0));
      c = '0; c.load_ir = 1'b1; tr.push_back(c);
      tr.push_back(ctl_t'(0));
      if (k == K_ILL) begin
         c = '0; c.illegal = 1'b1;
         for (int i = 0; i < 5; i++) tr.push_back(c);
         return;
      end
      imm = (k == K_LW) || (k == K_SW) || (k == K_ADDI);
      sb  = (k == K_SUB) || (k == K_BEQ);
      c = '0; c.din2 = imm; c.sub = sb;
      if (k == K_BEQ) begin
         c.din2 = 1'b0; c.load_pc = 1'b1; c.pc_src = z;
         tr.push_back(c);
         return;
      end
      tr.push_back(c);
      if (k == K_LW || k == K_SW) begin
         c = '0; c.din2 = 1'b1;
         for (int i = 0; i < mw; i++) tr.push_back(c);
         if (k == K_SW) begin
            c.we_mem = 1'b1; c.load_pc = 1'b1;
            tr.push_back(c);
            return;
         end
         tr.push_back(c);
      end
      c = '0; c.we_rf = 1'b1; c.load_pc = 1'b1; c.rfsel = (k != K_LW);
      c.din2 = imm; c.sub = sb;
      tr.push_back(c);
   endtask

   // Entered and left #1 after a posedge with the selected DUT in FETCH.
   task automatic run_instr(input int w, input logic [31:0] ins, input logic z, input string tag);
      ctl_t tr[$];
      ctl_t o;
      int   mw;
      mw = (w == 0) ? 0 : 2;
      build_trace(ins, mw, z, tr);
      if (w == 0) begin instr0 = ins; zero0 = z; end
      else        begin instr2 = ins; zero2 = z; end
      for (int j = 0; j < tr.size(); j++) begin
         @(negedge CLK);
         o = (w == 0) ? obs0 : obs2;
         checks++;
         if (o !== tr[j]) begin
            errors++;
            $display("FAIL %s w%0d ins=%08h cyc%0d: got %b expected %b", tag, mw, ins, j + 1, o, tr[j]);
         end
         @(posedge CLK);
         #1;
         if (j == mw + 1) begin
            if (w == 0) instr0 = $urandom;
            else        instr2 = $urandom;
         end
      end
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         checks++;
         if (obs0 !== ctl_t'(0) || obs2 !== ctl_t'(0)) begin
            errors++;
            $display("FAIL %s_during_reset: got %b/%b expected all zero", tag, obs0, obs2);
         end
      end
      @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (obs0 !== ctl_t'(0) || obs2 !== ctl_t'(0)) begin
         errors++;
         $display("FAIL %s_init: got %b/%b expected all zero", tag, obs0, obs2);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      apply_reset("reset");
   endtask

   task automatic test_lw();
      run_instr(0, 32'h00002083, 1'b0, "lw");
   endtask

   task automatic test_sw_back_to_back();
      run_instr(0, 32'h00302423, 1'b0, "sw");
      run_instr(0, 32'h00002083, 1'b1, "after_sw");
   endtask

   task automatic test_add_sub();
      run_instr(0, 32'h002081B3, 1'b0, "add");
      run_instr(0, 32'h40208233, 1'b1, "sub");
   endtask

   task automatic test_addi_wait();
      apply_reset("reset_w2");
      run_instr(1, 32'h00500293, 1'b0, "addi_w2");
      run_instr(1, 32'h00002083, 1'b0, "lw_w2");
      run_instr(1, 32'h00302423, 1'b0, "sw_w2");
   endtask

   task automatic test_illegal();
      apply_reset("reset_ill");
      run_instr(0, 32'hFFFFFFFF, 1'b0, "illegal");
      apply_reset("reset_after_ill");
      run_instr(0, 32'h002081B3, 1'b0, "add_after_ill");
   endtask

   task automatic test_branch();
      run_instr(0, 32'h00000463, 1'b1, "beq_z1");
      apply_reset("reset_beq");
      run_instr(0, 32'h00000463, 1'b0, "beq_z0");
      apply_reset("reset_beq2");
   endtask

   task automatic test_async_reset();
      instr0 = 32'h00002083;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (obs0.we_rf !== 1'b1) begin
         errors++;
         $display("FAIL async_pre_wb: got WE_RF=%b expected 1", obs0.we_rf);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs0 !== ctl_t'(0)) begin
         errors++;
         $display("FAIL async_drop: got %b expected all zero", obs0);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (obs0 !== ctl_t'(0)) begin
         errors++;
         $display("FAIL async_hold: got %b expected all zero", obs0);
      end
      apply_reset("reset_async");
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      int          k;
      r = $urandom;
      k = $urandom_range(7, 0);
      case (k)
         0: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
         1: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
         2: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0000000; end
         3: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0100000; end
         4: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
         5: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
         6: begin
            r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0000000;
            r[$urandom_range(31, 0)] ^= 1'b1;
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic test_random(input int w, input int n);
      logic [31:0] ins;
      apply_reset("reset_rand");
      for (int i = 0; i < n; i++) begin
         ins = gen_instr();
         run_instr(w, ins, 1'($urandom_range(1, 0)), "rand");
         if (classify(ins) == K_ILL) apply_reset("reset_rand_ill");
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_back_to_back();
      test_add_sub();
      test_addi_wait();
      test_illegal();
      test_branch();
      test_async_reset();
      test_random(0, 60);
      test_random(1, 40);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
